mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported instruction/data memory between the IF stage (fetch)
//  and the MEM stage (load/store) of the pipelined CPU. Arbitrates requests,
//  sequences each access over a fixed memory latency, and returns the response
//  to its owner. Default priority is data. A streak limit guarantees fetch progress.
// PARAMETERS
//  ADDR_W      32  address width, byte address
//  DATA_W      32  data width
//  LATENCY     1   memory read latency in cycles, legal 1..15 (1 = combinational array)
//  MAX_STREAK  4   maximum consecutive data grants while a fetch waits, legal 1..15
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       asynchronous reset, active-low
//  if_req_i     in   1       fetch request; hold until if_gnt_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_gnt_o     out  1       fetch request accepted this cycle
//  if_rvalid_o  out  1       one-cycle pulse: if_rdata_o valid
//  if_rdata_o   out  DATA_W  fetched instruction
//  dm_req_i     in   1       data request; hold until dm_gnt_o
//  dm_we_i      in   1       1 = store, 0 = load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_gnt_o     out  1       data request accepted this cycle
//  dm_rvalid_o  out  1       one-cycle pulse: load data valid, or store done
//  dm_rdata_o   out  DATA_W  load data; 0 for stores
//  mem_en_o     out  1       memory command strobe
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_rdata_i  in   DATA_W  memory read data
//  busy_o       out  1       access in flight (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latency counter 0, streak counter 0.
//   Reset is honoured mid-access. The in-flight access is dropped and no rvalid is issued.
//  States:
//   IDLE: arbitrate. gnt is combinational from the current-cycle reqs.
//    In grant cycle C, exactly one gnt is high and the request fields are latched.
//    The block goes to WAIT with cnt = LATENCY.
//   WAIT: mem_en_o and mem_we_o are high only in cycle C+1. mem_addr_o and
//    mem_wdata_o are held for the whole of WAIT. cnt decrements each cycle.
//    When cnt == 1, mem_rdata_i is captured into the owner's rdata_o
//    (0 for a store) and the state returns to IDLE.
//  Response: owner's rvalid_o pulses in cycle C+LATENCY+1. The next grant can
//   occur in that same cycle (back-to-back; throughput 1 access per LATENCY+1).
//  No gnt is issued outside IDLE. Requesters simply keep req high.
//  rdata_o holds its last value between responses. rvalid_o is never high on both ports.
//  Arbitration, when both reqs are high:
//   - dm wins unless streak == MAX_STREAK; in that case if wins.
//   - streak +1 (saturating) on each dm grant made while if_req_i is high.
//   - streak is cleared on any if grant, or on a dm grant while if_req_i is low.
//   - A single request is always granted in IDLE.
//  Addresses are passed through unmodified; word alignment is the requester's job.
// TESTING
//  1. LATENCY=1, if_req at 0x0 only: if_gnt in cycle C, mem_en in C+1, if_rvalid in C+2 with mem[0].
//  2. LATENCY=3, dm load at 0x10, then an immediately following fetch: dm_rvalid at C+4;
//     if_gnt in cycle C+4, if_rvalid at C+8.
//  3. Both reqs held high continuously, MAX_STREAK=4: grant order is dm,dm,dm,dm,if,dm,dm,dm,dm,if.
//  4. Store dm_we=1, addr 0x8, wdata 0xDEADBEEF: mem_we pulses once with the matching
//     addr/wdata; dm_rvalid pulses with dm_rdata=0; a later load from 0x8 returns 0xDEADBEEF.
//  5. rst_i low during WAIT (LATENCY=3): all outputs 0 immediately, no rvalid afterwards;
//     a req after release is granted normally.
//  6. Bench asserts every cycle: never gnt outside IDLE, never both gnt, never both rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data load/store.
// Data has priority; a streak limit guarantees that a waiting fetch eventually gets through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(LATENCY);
  localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);

  state_t            state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic [3:0]        streak_q,    streak_d;
  logic              owner_dm_q,  owner_dm_d;
  logic              acc_we_q,    acc_we_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;

  logic if_win;
  logic dm_win;

  // Grant decision: data wins a tie unless the fetch has been starved MAX_STREAK times.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (state_q == ST_IDLE) begin
      if (dm_req_i && if_req_i) begin
        if (streak_q >= STREAK_LIM) if_win = 1'b1;
        else                        dm_win = 1'b1;
      end else if (dm_req_i) begin
        dm_win = 1'b1;
      end else if (if_req_i) begin
        if_win = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_dm_d  = owner_dm_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (if_win || dm_win) begin
          state_d     = ST_WAIT;
          cnt_d       = LAT_INIT;
          owner_dm_d  = dm_win;
          acc_we_d    = dm_win && dm_we_i;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_win && dm_we_i;
          mem_addr_d  = dm_win ? dm_addr_i : if_addr_i;
          mem_wdata_d = (dm_win && dm_we_i) ? dm_wdata_i : '0;
        end
        // Streak only counts data grants that actually held a fetch back.
        if (dm_win && if_req_i) begin
          if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
        end else if (if_win || dm_win) begin
          streak_d = 4'd0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = acc_we_q ? '0 : mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      owner_dm_q  <= 1'b0;
      acc_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_dm_q  <= owner_dm_d;
      acc_we_q    <= acc_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held to keep every output low.
  assign if_gnt_o    = if_win && rst_i;
  assign dm_gnt_o    = dm_win && rst_i;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
